pe_load_sequencer: RTL and testbench

//  Credit-based multi-channel load sequencer between the on-chip bus and one PE.

---
 rtl/pe_load_sequencer_if.sv | 39 +++
 rtl/pe_load_sequencer.sv | 155 +++++++++++++++
 tb/tb_pe_load_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_load_sequencer_if.sv
// Command, bus-source and PE-side signals of the PE load sequencer.
// master = command/bus/PE environment, slave = sequencer.
interface pe_load_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 3,
    parameter int CH_W       = 2,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CH_W-1:0]       cmd_ch;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  cmd_full_col;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;
    logic                  src_ready;
    logic [NUM_CH-1:0]     pe_start;
    logic                  pe_full_col;
    logic [DATA_WIDTH-1:0] pe_data;
    logic [NUM_CH-1:0]     pe_en;
    logic [NUM_CH-1:0]     pe_pop;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_ch, cmd_len, cmd_full_col,
        output src_data, src_valid, pe_pop,
        input  cmd_ready, src_ready, pe_start, pe_full_col,
        input  pe_data, pe_en, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_len, cmd_full_col,
        input  src_data, src_valid, pe_pop,
        output cmd_ready, src_ready, pe_start, pe_full_col,
        output pe_data, pe_en, busy, done, err
    );
endinterface

// File: rtl/pe_load_sequencer.sv
// Credit-based multi-channel load sequencer feeding one PE's input FIFOs.
// Optional PE_SEQ_TIMEOUT_EN: abort a stalled STREAM after TIMEOUT_CYC cycles.
module pe_load_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CH       = 3,
    parameter int CH_W         = 2,
    parameter int LEN_WIDTH    = 8,
    parameter int PE_FIFO_SIZE = 2,
    parameter int TIMEOUT_CYC  = 64
) (
    input logic                clk,
    input logic                rst,
    pe_load_sequencer_if.slave bus
);
    localparam int CRW = $clog2(PE_FIFO_SIZE + 1);
    localparam logic [CRW-1:0] LP_FULL = CRW'(PE_FIFO_SIZE);
    localparam logic [CH_W:0] LP_NCH = (CH_W + 1)'(NUM_CH);

    if (2 ** CH_W < NUM_CH) begin : g_ch_w_chk
        $error("CH_W too narrow for NUM_CH");
    end
    if (TIMEOUT_CYC < 1) begin : g_to_chk
        $error("TIMEOUT_CYC must be positive");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CH_W-1:0]       r_ch;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_full_col;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NUM_CH-1:0]     r_en;
    logic                  r_err;
    logic [CRW-1:0]        r_credit [NUM_CH];

    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_nz;
    logic [NUM_CH-1:0] w_issue;
    logic              w_accept;
    logic              w_bad;
    logic              w_src_rdy;
    logic              w_xfer;
    logic              w_last;
    logic              w_timeout;

    always_comb begin
        w_sel = '0;
        w_nz  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sel[c] = (r_ch == CH_W'(c));
            w_nz[c]  = (r_credit[c] != '0);
        end
    end

    assign w_accept  = bus.cmd_valid && (r_state == S_IDLE);
    assign w_bad     = ({1'b0, bus.cmd_ch} >= LP_NCH);
    assign w_src_rdy = (r_state == S_STREAM) && (|(w_sel & w_nz)) &&
                       (r_rem != '0);
    assign w_xfer    = bus.src_valid && w_src_rdy;
    assign w_last    = (r_rem == LEN_WIDTH'(1));
    assign w_issue   = w_xfer ? w_sel : '0;

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (r_state != S_STREAM || w_xfer) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_STREAM) && !w_xfer &&
                       (r_stall == TW'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept && !w_bad) w_next = S_START;
            S_START:  w_next = (r_rem == '0) ? S_DONE : S_STREAM;
            S_STREAM: begin
                if (w_timeout)           w_next = S_IDLE;
                else if (w_xfer && w_last) w_next = S_DONE;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch       <= '0;
            r_rem      <= '0;
            r_full_col <= 1'b0;
            r_data     <= '0;
            r_en       <= '0;
            r_err      <= 1'b0;
        end else begin
            r_en  <= w_issue;
            r_err <= (w_accept && w_bad) || w_timeout;
            if (w_xfer) begin
                r_data <= bus.src_data;
                r_rem  <= r_rem - 1'b1;
            end
            if (w_accept) begin
                r_ch       <= bus.cmd_ch;
                r_rem      <= bus.cmd_len;
                r_full_col <= bus.cmd_full_col;
            end
        end
    end

    // pop and issue in the same cycle cancel; pops beyond full saturate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) r_credit[c] <= LP_FULL;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case ({bus.pe_pop[c], w_issue[c]})
                    2'b10: if (r_credit[c] != LP_FULL)
                               r_credit[c] <= r_credit[c] + 1'b1;
                    2'b01: r_credit[c] <= r_credit[c] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.src_ready   = w_src_rdy;
    assign bus.pe_start    = (r_state == S_START) ? w_sel : '0;
    assign bus.pe_full_col = r_full_col;
    assign bus.pe_data     = r_data;
    assign bus.pe_en       = r_en;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.err         = r_err;
endmodule

// File: tb/tb_pe_load_sequencer.sv
// Directed bench for pe_load_sequencer: command table plus corner sequences.
// Timeout expectations follow PE_SEQ_TIMEOUT_EN when it is defined.
module tb_pe_load_sequencer;
    localparam int DW = 16;
    localparam int NCH = 3;
    localparam int CHW = 2;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_bad = 0;

    pe_load_sequencer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH),
                           .CH_W(CHW), .LEN_WIDTH(LW)) bus ();

    pe_load_sequencer #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_W(CHW), .LEN_WIDTH(LW),
        .PE_FIFO_SIZE(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        int          len;
        logic        fc;
        logic [15:0] base;
        logic [2:0]  x_start;
        int          x_words;
        int          x_done;
        int          x_err;
    } vec_t;

    vec_t tbl [6];

    int t, words, dones, errs, starts, sent;
    int t_start, t_done, t_last, t_err;
    logic [2:0] smask, psh;
    logic [15:0] base_q;
    logic fc_q;
    bit took, busy_seen, fc_bad, ended;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_cmd(input logic [15:0] base, input logic fc);
        t = 0; words = 0; dones = 0; errs = 0; starts = 0; sent = 0;
        t_start = -1; t_done = -1; t_last = -1; t_err = -1;
        smask = '0; psh = '0; base_q = base; fc_q = fc;
        took = 0; busy_seen = 0; fc_bad = 0; ended = 0;
        bus.src_data = base;
    endtask

    task automatic issue(input int ch, input int len, input logic fc);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            tick();
            k++;
        end
        chk("cmd_ready_wait", int'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch = 2'(ch);
        bus.cmd_len = 8'(len);
        bus.cmd_full_col = fc;
        tick();
        bus.cmd_valid = 1'b0;
        t = 1;
    endtask

    task automatic sample_cycle(input int ch, input int pm);
        logic [2:0] oh;
        oh = 3'(1 << ch);
        if (took) sent++;
        bus.src_data = base_q + 16'(sent);
        if (bus.pe_start != '0) begin
            starts++;
            smask |= bus.pe_start;
            t_start = t;
            if (bus.pe_full_col !== fc_q) fc_bad = 1;
        end
        if (bus.pe_en != '0) begin
            chk("pe_data", int'(bus.pe_data), int'(base_q + 16'(words)));
            chk("pe_en", int'(bus.pe_en), int'(oh));
            words++;
            t_last = t;
        end
        if (bus.done) begin
            dones++;
            t_done = t;
        end
        if (bus.err) begin
            if (errs == 0) t_err = t;
            errs++;
        end
        if (bus.busy) busy_seen = 1;
        psh = {psh[1:0], bus.pe_en != '0};
        if (pm == 2) bus.pe_pop = 3'b111;
        else if (pm == 1 && psh[2]) bus.pe_pop = oh;
        else bus.pe_pop = 3'b000;
        took = bus.src_valid && bus.src_ready;
    endtask

    task automatic run_cycles(input int ch, input int pm, input int n,
                              input bit stop);
        int extra;
        extra = 8;
        for (int i = 0; i < n; i++) begin
            sample_cycle(ch, pm);
            if (stop && (dones > 0 || errs > 0)) begin
                ended = 1;
                if (extra == 0) break;
                extra--;
            end
            tick();
            t++;
        end
        bus.pe_pop = 3'b000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd0, 6, 1'b0, 16'd1,     3'b001, 6, 1, 0};
        tbl[1] = '{2'd1, 3, 1'b1, 16'h0100,  3'b010, 3, 1, 0};
        tbl[2] = '{2'd2, 0, 1'b0, 16'h0200,  3'b100, 0, 1, 0};
        tbl[3] = '{2'd3, 4, 1'b1, 16'h0300,  3'b000, 0, 0, 1};
        tbl[4] = '{2'd2, 2, 1'b1, 16'h0400,  3'b100, 2, 1, 0};
        tbl[5] = '{2'd0, 1, 1'b0, 16'h0500,  3'b001, 1, 1, 0};

        rst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_ch = '0; bus.cmd_len = '0;
        bus.cmd_full_col = 0; bus.src_valid = 0; bus.src_data = '0;
        bus.pe_pop = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_src_ready", int'(bus.src_ready), 0);
        chk("rst_pe_en", int'(bus.pe_en), 0);
        chk("rst_pe_start", int'(bus.pe_start), 0);
        chk("rst_done_err", int'({bus.done, bus.err}), 0);
        chk("rst_pe_data", int'(bus.pe_data), 0);
        chk("rst_full_col", int'(bus.pe_full_col), 0);

        // reset mid-STREAM, then credits must be full again
        begin_cmd(16'h0020, 1'b0);
        bus.src_valid = 1;
        issue(0, 6, 1'b0);
        run_cycles(0, 0, 3, 0);
        chk("pre_rst_en", int'(bus.pe_en), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_ready", int'(bus.cmd_ready), 1);
        chk("mid_rst_en", int'(bus.pe_en), 0);
        rst = 1'b0;
        begin_cmd(16'h0030, 1'b0);
        issue(0, 2, 1'b0);
        run_cycles(0, 0, 20, 0);
        chk("post_rst_words", words, 2);
        chk("post_rst_done", dones, 1);
        run_cycles(0, 2, 3, 0);

        // no pops: two credits only, then one pop frees one word
        begin_cmd(16'h0050, 1'b0);
        issue(1, 5, 1'b0);
        run_cycles(1, 0, 20, 0);
        chk("nopop_words", words, 2);
        chk("nopop_src_ready", int'(bus.src_ready), 0);
        chk("nopop_busy", int'(bus.busy), 1);
        bus.pe_pop = 3'b010;
        tick();
        t++;
        bus.pe_pop = 3'b000;
        chk("ready_after_pop", int'(bus.src_ready), 1);
        run_cycles(1, 0, 10, 0);
        chk("one_pop_words", words, 3);
        chk("one_pop_src_ready", int'(bus.src_ready), 0);
        run_cycles(1, 2, 40, 1);
        chk("drain_words", words, 5);
        chk("drain_done", dones, 1);
        chk("drain_err", errs, 0);
        chk("drain_end", int'(ended), 1);

        // pops at full credit saturate: still exactly 2 words
        begin_cmd(16'h0070, 1'b0);
        issue(1, 3, 1'b0);
        run_cycles(1, 0, 20, 0);
        chk("sat_words", words, 2);
        run_cycles(1, 2, 30, 1);
        chk("sat_drain_words", words, 3);
        chk("sat_drain_done", dones, 1);

        for (int v = 0; v < 6; v++) begin
            begin_cmd(tbl[v].base, tbl[v].fc);
            bus.src_valid = 1;
            issue(int'(tbl[v].ch), tbl[v].len, tbl[v].fc);
            run_cycles(int'(tbl[v].ch), 1, 200, 1);
            chk($sformatf("v%0d_end", v), int'(ended), 1);
            chk($sformatf("v%0d_start", v), int'(smask), int'(tbl[v].x_start));
            chk($sformatf("v%0d_nstart", v), starts,
                (tbl[v].x_start != 0) ? 1 : 0);
            chk($sformatf("v%0d_full_col", v), int'(fc_bad), 0);
            chk($sformatf("v%0d_words", v), words, tbl[v].x_words);
            chk($sformatf("v%0d_done", v), dones, tbl[v].x_done);
            chk($sformatf("v%0d_err", v), errs, tbl[v].x_err);
            chk($sformatf("v%0d_busy", v), int'(busy_seen),
                tbl[v].x_err ? 0 : 1);
            if (tbl[v].x_err != 0)
                chk($sformatf("v%0d_t_err", v), t_err, 1);
            else if (tbl[v].x_words == 0)
                chk($sformatf("v%0d_t_done", v), t_done, t_start + 1);
            else
                chk($sformatf("v%0d_t_done", v), t_done, t_last);
        end
        bus.src_valid = 0;

        // source stalls inside STREAM
        begin_cmd(16'h0090, 1'b0);
        issue(0, 3, 1'b0);
`ifdef PE_SEQ_TIMEOUT_EN
        run_cycles(0, 1, 30, 0);
        chk("to_err", errs, 1);
        chk("to_t_err", t_err, 18);
        chk("to_done", dones, 0);
        chk("to_busy", int'(bus.busy), 0);
        chk("to_ready", int'(bus.cmd_ready), 1);
        chk("to_words", words, 0);
`else
        run_cycles(0, 1, 100, 0);
        chk("stall_busy", int'(bus.busy), 1);
        chk("stall_done", dones, 0);
        chk("stall_err", errs, 0);
        chk("stall_words", words, 0);
        bus.src_valid = 1;
        run_cycles(0, 1, 40, 1);
        chk("resume_words", words, 3);
        chk("resume_done", dones, 1);
        chk("resume_t_done", t_done, t_last);
`endif
        bus.src_valid = 0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
